// File: rtl/float_pkg.sv
// Shared float helpers: operand classes, reciprocal FSM states
// and constant builders for the Q2.W datapath.
package float_pkg;

  typedef enum logic [1:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } fclass_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_MUL_DY,
    S_MUL_YE,
    S_PACK,
    S_DONE
  } state_e;

  function automatic int bias_of(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // num/den as a fixed-point value with w fraction bits
  function automatic logic [63:0] q_ratio(
    input int num,
    input int den,
    input int w
  );
    return (64'(num) << w) / 64'(den);
  endfunction

endpackage

// File: rtl/float_recip_iter_if.sv
// Operand / result valid-ready bundle for the
// iterative reciprocal.
interface float_recip_iter_if #(
  parameter int FLOAT_SIZE = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [FLOAT_SIZE-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [FLOAT_SIZE-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/float_classify.sv
// Combinational float unpacker: sign, exponent,
// fraction and operand class.
module float_classify
  import float_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic [EXP_W+MANT_W:0] data_i,
  output logic                  sign_o,
  output logic [EXP_W-1:0]      exp_o,
  output logic [MANT_W-1:0]     frac_o,
  output fclass_e               cls_o
);

  assign sign_o = data_i[EXP_W+MANT_W];
  assign exp_o  = data_i[MANT_W +: EXP_W];
  assign frac_o = data_i[MANT_W-1:0];

  always_comb begin
    cls_o = CLS_NORMAL;
    unique case (1'b1)
      (exp_o == '0):
        cls_o = CLS_ZERO;
      (exp_o == '1) && (frac_o == '0):
        cls_o = CLS_INF;
      (exp_o == '1) && (frac_o != '0):
        cls_o = CLS_NAN;
      default:
        cls_o = CLS_NORMAL;
    endcase
  end

endmodule

// File: rtl/float_recip_iter.sv
// Low-area float reciprocal: one shared multiplier
// reused for the seed and every Newton step.
module float_recip_iter
  import float_pkg::*;
#(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int ITERATIONS    = 3,
  parameter int FLOAT_SIZE    = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
  input logic               clk,
  input logic               resetn,
  float_recip_iter_if.slave io
);

  localparam int ME   = MANTISSA_SIZE;
  localparam int EW   = EXPONENT_SIZE;
  localparam int W    = ME + 4;
  localparam int QW   = W + 2;
  localparam int BIAS = bias_of(EW);

  localparam logic [EW-1:0] EXP_ALL_ONES = '1;
  localparam logic [FLOAT_SIZE-1:0] CANONICAL_NAN =
    {1'b0, EXP_ALL_ONES, 1'b1, {(ME-1){1'b0}}};
  localparam logic [QW-1:0] SEED_A = QW'(q_ratio(48, 17, W));
  localparam logic [QW-1:0] SEED_B = QW'(q_ratio(32, 17, W));
  localparam logic [QW-1:0] TWO    = {2'b10, {W{1'b0}}};
  localparam logic [2:0]    ITER_N = 3'(ITERATIONS);

  logic          c_sign;
  logic [EW-1:0] c_exp;
  logic [ME-1:0] c_frac;
  fclass_e       c_cls;

  float_classify #(
    .EXP_W (EW),
    .MANT_W(ME)
  ) u_cls (
    .data_i(io.in_data),
    .sign_o(c_sign),
    .exp_o (c_exp),
    .frac_o(c_frac),
    .cls_o (c_cls)
  );

  state_e                state_q;
  logic                  sign_q;
  logic [EW-1:0]         exp_q;
  logic [ME-1:0]         frac_q;
  fclass_e               cls_q;
  logic [QW-1:0]         y_q;
  logic [QW-1:0]         t_q;
  logic [2:0]            cnt_q;
  logic                  out_valid_q;
  logic [FLOAT_SIZE-1:0] out_data_q;

  logic [QW-1:0]   d_w;
  logic [QW-1:0]   op_a;
  logic [QW-1:0]   op_b;
  logic [2*QW-1:0] prod;
  logic [QW-1:0]   p;

  assign d_w  = {2'b00, 1'b1, frac_q, {(W-ME-1){1'b0}}};

  always_comb begin
    op_a = d_w;
    op_b = y_q;
    unique case (1'b1)
      (state_q == S_SEED): begin
        op_a = SEED_B;
        op_b = d_w;
      end
      (state_q == S_MUL_YE): begin
        op_a = y_q;
        op_b = TWO - t_q;
      end
      default: ;
    endcase
  end

  assign prod = (2*QW)'(op_a) * (2*QW)'(op_b);
  assign p    = prod[W +: QW];

  logic [QW:0]           y_rnd;
  logic                  carry;
  logic [ME-1:0]         mant;
  int                    e_int;
  logic [FLOAT_SIZE-1:0] pack_d;

  assign y_rnd = {1'b0, y_q} + (QW+1)'(1 << (W - ME - 1));
  assign carry = y_rnd[W+1];

  always_comb begin
    mant  = carry ? '0 : y_rnd[W-1 -: ME];
    e_int = 2 * BIAS - int'(exp_q);
    if (frac_q != '0)
      e_int = e_int - 1 + (carry ? 1 : 0);
    else
      mant = '0;
    pack_d = {sign_q, e_int[EW-1:0], mant};
    if (e_int <= 0)
      pack_d = {sign_q, {(FLOAT_SIZE-1){1'b0}}};
    unique case (cls_q)
      CLS_ZERO: pack_d = {sign_q, EXP_ALL_ONES, {ME{1'b0}}};
      CLS_INF:  pack_d = {sign_q, {(FLOAT_SIZE-1){1'b0}}};
      CLS_NAN:  pack_d = CANONICAL_NAN;
      default: ;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{y_rnd[QW], y_rnd[W], y_rnd[W-ME-1:0],
                       prod[W-1:0], prod[2*QW-1:W+QW]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      frac_q      <= '0;
      cls_q       <= CLS_NORMAL;
      y_q         <= '0;
      t_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (io.in_valid) begin
          sign_q  <= c_sign;
          exp_q   <= c_exp;
          frac_q  <= c_frac;
          cls_q   <= c_cls;
          cnt_q   <= '0;
          state_q <= S_SEED;
        end
        S_SEED: begin
          y_q     <= SEED_A - p;
          state_q <= S_MUL_DY;
        end
        S_MUL_DY: begin
          t_q     <= p;
          state_q <= S_MUL_YE;
        end
        S_MUL_YE: begin
          y_q     <= p;
          cnt_q   <= cnt_q + 3'd1;
          state_q <= (cnt_q + 3'd1 < ITER_N) ? S_MUL_DY : S_PACK;
        end
        S_PACK: begin
          out_data_q  <= pack_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: if (io.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;

endmodule

// File: tb/tb_float_recip_iter.sv
// Scoreboard bench for float_recip_iter: directed
// operands, queued expectations, negedge monitor.
module tb_float_recip_iter;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  float_recip_iter_if #(.FLOAT_SIZE(32)) bus ();

  float_recip_iter dut (
    .clk   (clk),
    .resetn(resetn),
    .io    (bus)
  );

  typedef struct {
    logic [31:0] val;
    int          tol;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  always @(negedge clk) begin
    if (resetn && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got %h expected none",
                 bus.out_data);
      end else begin
        exp_t e;
        int   diff;
        e    = sb.pop_front();
        diff = int'(bus.out_data) - int'(e.val);
        if (diff < 0) diff = -diff;
        n_checks++;
        if (diff <= e.tol) n_pass++;
        else $display("FAIL result: got %h expected %h (tol %0d)",
                      bus.out_data, e.val, e.tol);
      end
    end
  end

  task automatic issue(input logic [31:0] x,
                       input logic [31:0] e,
                       input int tol,
                       input bit push);
    int n;
    exp_t it;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) check("issue_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    it.val = e;
    it.tol = tol;
    if (push) sb.push_back(it);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.out_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_one(input logic [31:0] x,
                         input logic [31:0] e,
                         input int tol);
    int n;
    issue(x, e, tol, 1'b1);
    wait_valid(n);
    @(posedge clk); #1;
  endtask

  logic [31:0] vec_in [10] = '{
    32'h40800000, 32'h40400000, 32'hC0400000, 32'h3FC00000,
    32'h80000000, 32'h7F800000, 32'h7FC00001, 32'h00000001,
    32'h7F000000, 32'h7E800000
  };
  logic [31:0] vec_out[10] = '{
    32'h3E800000, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'h3F2AAAAB,
    32'hFF800000, 32'h00000000, 32'h7FC00000, 32'h7F800000,
    32'h00000000, 32'h00800000
  };
  int vec_tol[10] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0};

  initial begin
    int          n;
    logic [31:0] held;
    bit          stable, vhigh, rdy_low, rdy;

    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    issue(32'h3F800000, 32'h3F800000, 0, 1'b1);
    wait_valid(n);
    check("latency", 32'(n), 32'd8);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_one(vec_in[i], vec_out[i], vec_tol[i]);

    bus.out_ready = 1'b0;
    issue(32'h40000000, 32'h3F000000, 0, 1'b1);
    wait_valid(n);
    held    = bus.out_data;
    stable  = 1'b1;
    vhigh   = 1'b1;
    rdy_low = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_data !== held) stable = 1'b0;
      if (bus.out_valid !== 1'b1) vhigh = 1'b0;
      if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
    end
    check("stall_data", 32'(stable), 32'd1);
    check("stall_valid", 32'(vhigh), 32'd1);
    check("stall_in_ready", 32'(rdy_low), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("handshake_in_ready", 32'(bus.in_ready), 32'd1);

    sb.push_back('{val: 32'h3E800000, tol: 0});
    sb.push_back('{val: 32'h3F000000, tol: 0});
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h40800000;
    @(posedge clk); #1;
    bus.in_data = 32'h40000000;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 40) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    bus.in_valid = 1'b0;
    check("issue_interval", 32'(n), 32'd10);
    wait_valid(n);
    @(posedge clk); #1;

    issue(32'h40400000, 32'h0, 0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    n = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (bus.out_valid) n++;
    end
    check("no_stale_result", 32'(n), 32'd0);
    run_one(32'h40000000, 32'h3F000000, 0);

    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); n++;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
